// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter sharing the write port of one WIDTH-bit data register
// among N_REQ requesters, with a per-grant burst limit of MAX_BURST writes.
module dff_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int BW       = $clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [OW-1:0]          owner,
  output logic                   busy,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid
);

  localparam logic [0:0]    IDLE      = 1'b0;
  localparam logic [0:0]    OWN       = 1'b1;
  localparam logic [OW-1:0] LAST_IDX  = OW'(N_REQ - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  logic [0:0]       state_r;
  logic [OW-1:0]    ptr_r;
  logic [BW-1:0]    burst_cnt_r;

  logic             own_req_s;
  logic [WIDTH-1:0] wsel_s;
  logic             release_s;
  logic [OW-1:0]    next_ptr_s;
  logic [OW-1:0]    arb_ptr_s;
  logic             found_s;
  logic [OW-1:0]    winner_s;

  // First requester at or after start, wrapping modulo N_REQ; MSB flags a hit.
  function automatic logic [OW:0] pick_winner(input logic [N_REQ-1:0] r,
                                               input logic [OW-1:0]    start);
    logic          hit;
    logic [OW-1:0] win;
    logic [OW-1:0] ii;
    int            idx;
    hit = 1'b0;
    win = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx + 0;
      end
      ii = OW'(idx);
      if (!hit && r[ii]) begin
        hit = 1'b1;
        win = ii;
      end else begin
        hit = hit;
      end
    end
    return {hit, win};
  endfunction

  // Owner request/data selection, release decision and arbitration.
  always_comb begin
    own_req_s  = req[owner];
    wsel_s     = wdata[owner*WIDTH +: WIDTH];
    next_ptr_s = (owner == LAST_IDX) ? '0 : owner + OW'(1);
    if (state_r == OWN) begin
      release_s = !own_req_s || (burst_cnt_r == LAST_BEAT);
      arb_ptr_s = next_ptr_s;
    end else begin
      release_s = 1'b0;
      arb_ptr_s = ptr_r;
    end
    {found_s, winner_s} = pick_winner(req, arb_ptr_s);
  end

  // Arbiter state, grant and shared data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      burst_cnt_r <= '0;
      owner       <= '0;
      gnt         <= '0;
      q           <= '0;
      q_valid     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          q_valid     <= 1'b0;
          burst_cnt_r <= '0;
          if (found_s) begin
            state_r <= OWN;
            owner   <= winner_s;
            gnt     <= {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
          end else begin
            owner <= '0;
            gnt   <= '0;
          end
        end
        OWN: begin
          q_valid <= own_req_s;
          if (own_req_s) begin
            q           <= wsel_s;
            burst_cnt_r <= burst_cnt_r + BW'(1);
          end else begin
            q <= q;
          end
          if (release_s) begin
            ptr_r       <= next_ptr_s;
            burst_cnt_r <= '0;
            if (found_s) begin
              owner <= winner_s;
              gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
            end else begin
              state_r <= IDLE;
              owner   <= '0;
              gnt     <= '0;
            end
          end else begin
            ptr_r <= ptr_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          owner       <= '0;
          gnt         <= '0;
          burst_cnt_r <= '0;
          q_valid     <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state_r == OWN);

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed self-checking bench for dff_write_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=4).
module tb_dff_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  q;
  logic        q_valid;

  int n_chk  = 0;
  int n_fail = 0;

  dff_write_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt), .owner(owner), .busy(busy), .q(q), .q_valid(q_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order[5];
    int g;
    order = '{0, 1, 2, 3, 0};

    // Reset with junk on the inputs
    rst = 1'b1; req = 4'b1111; wdata = 32'hDEADBEEF;
    tick(); tick();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_q", q, 8'h00);
    check("rst_qv", q_valid, 1'b0);
    rst = 1'b0; req = 4'b0000;
    tick();
    check("rst_rel_gnt", gnt, 4'b0000);
    check("rst_rel_busy", busy, 1'b0);
    check("rst_rel_q", q, 8'h00);

    // Single requester 2
    req = 4'b0100; wdata = 32'h00A50000;
    tick();
    check("single_gnt", gnt, 4'b0100);
    check("single_owner", owner, 2'd2);
    check("single_busy", busy, 1'b1);
    check("single_qv0", q_valid, 1'b0);
    tick();
    check("single_q", q, 8'hA5);
    check("single_qv", q_valid, 1'b1);
    req = 4'b0000;
    tick();
    check("single_drop_gnt", gnt, 4'b0000);
    check("single_drop_busy", busy, 1'b0);
    check("single_drop_qv", q_valid, 1'b0);
    check("single_drop_q", q, 8'hA5);
    check("single_drop_owner", owner, 2'd0);

    // Burst limit: ptr is now 3, so requester 0 wins over 1
    req = 4'b0011; wdata = 32'h00005510;
    tick();
    check("burst_gnt0", gnt, 4'b0001);
    for (int j = 0; j < 4; j++) begin
      wdata[7:0] = 8'h10 + 8'(j);
      tick();
      check("burst_q", q, 8'h10 + 8'(j));
      check("burst_qv", q_valid, 1'b1);
      check("burst_gnt", gnt, (j < 3) ? 4'b0001 : 4'b0010);
    end
    tick();
    check("burst_r1_q", q, 8'h55);
    check("burst_r1_owner", owner, 2'd1);
    req = 4'b0000;
    tick();
    check("burst_idle_gnt", gnt, 4'b0000);
    check("burst_idle_qv", q_valid, 1'b0);

    // Fair rotation from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b1111; wdata = 32'h03020100;
    tick();
    check("rot_gnt_first", gnt, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      g = order[k];
      for (int w = 0; w < 4; w++) begin
        tick();
        check("rot_q", q, 32'(g));
        check("rot_qv", q_valid, 1'b1);
        check("rot_gnt", gnt, (w < 3) ? (4'b0001 << g) : (4'b0001 << ((g + 1) % 4)));
      end
    end
    req = 4'b0000;
    tick();
    check("rot_idle_gnt", gnt, 4'b0000);

    // Sole owner at the burst limit is re-granted (ptr is now 2)
    req = 4'b1000; wdata = 32'hC0000000;
    tick();
    check("sole_gnt0", gnt, 4'b1000);
    for (int j = 0; j < 6; j++) begin
      wdata[31:24] = 8'hC0 + 8'(j);
      tick();
      check("sole_q", q, 8'hC0 + 8'(j));
      check("sole_qv", q_valid, 1'b1);
      check("sole_gnt", gnt, 4'b1000);
    end
    req = 4'b0000;
    tick();
    check("sole_idle_busy", busy, 1'b0);

    // Reset during requester 1's second write (ptr is now 0)
    req = 4'b0010; wdata = 32'h00002100;
    tick();
    check("mid_gnt", gnt, 4'b0010);
    tick();
    check("mid_q1", q, 8'h21);
    wdata[15:8] = 8'h22; rst = 1'b1;
    tick();
    check("mid_rst_q", q, 8'h00);
    check("mid_rst_gnt", gnt, 4'b0000);
    check("mid_rst_qv", q_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    check("mid_regnt", gnt, 4'b0010);
    check("mid_regnt_qv", q_valid, 1'b0);
    for (int j = 0; j < 4; j++) begin
      wdata[15:8] = 8'h30 + 8'(j);
      tick();
      check("mid_burst_q", q, 8'h30 + 8'(j));
      check("mid_burst_qv", q_valid, 1'b1);
      check("mid_burst_gnt", gnt, 4'b0010);
    end
    req = 4'b0000;
    tick();
    check("end_idle_gnt", gnt, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_write_arbiter.md
# dff_write_arbiter

Round-robin arbiter that shares the write port of a single WIDTH-bit D-flip-flop data register among N_REQ requesters. Each requester raises a request, receives a registered one-hot grant, and may write the register on consecutive cycles up to MAX_BURST times before the grant rotates. It sits between the requesting blocks and the shared register, and provides the register output plus a one-cycle write strobe to downstream logic.

## Interface
- N_REQ, 4, number of requesters; legal range 2..16
- WIDTH, 8, data register width in bits
- MAX_BURST, 4, maximum writes per grant; legal range 1..255
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req  input  N_REQ  request per requester; bit i belongs to requester i
- wdata  input  N_REQ*WIDTH  write data; requester i drives wdata[i*WIDTH +: WIDTH]
- gnt  output  N_REQ  registered one-hot grant (all-zero when idle)
- owner  output  max(1,$clog2(N_REQ))  index of current grant holder; valid only while busy
- busy  output  1  high while a grant is held
- q  output  WIDTH  shared data register contents
- q_valid  output  1  one-cycle strobe: q was written on the preceding edge

## Operation
- Internal state: state {IDLE, OWN}, owner, burst_cnt (width $clog2(MAX_BURST+1)), round-robin pointer ptr.
- Winner selection: lowest index i, searching ptr, ptr+1, ... wrapping modulo N_REQ, such that req[i]=1.
- IDLE, at each edge: if any req bit set -> state<=OWN, owner<=winner, gnt<=onehot(winner), burst_cnt<=0. Otherwise stay IDLE, gnt=0. No register write occurs in IDLE.
- OWN, at each edge:
  - If req[owner]=1: q<=wdata slice of owner, q_valid<=1, burst_cnt<=burst_cnt+1.
  - If req[owner]=0: no write, q_valid<=0, q holds.
  - Release when req[owner]=0, or when this edge performs write number MAX_BURST (burst_cnt==MAX_BURST-1 with req[owner]=1).
  - On release: ptr<=(owner+1) mod N_REQ; re-arbitrate on the same edge using the new ptr against the current req. Winner found -> stay OWN, new owner/gnt, burst_cnt<=0. No winner -> IDLE, gnt<=0.
  - Burst-limit release with only the owner requesting: owner is re-granted (it is last in rotation order); burst_cnt restarts at 0.
- req bits of non-owners never affect q; wdata of non-owners is ignored.
- Requesters must hold wdata stable while req and gnt are both high; each cycle with req[i]&gnt[i] high is exactly one write.
- busy = (state==OWN); owner reads 0 in IDLE.

## Timing
- Reset (rst=1 at an edge): state=IDLE, gnt=0, owner=0, busy=0, q=0, q_valid=0, ptr=0, burst_cnt=0. Reset wins over every other event, including mid-burst; the in-flight write on that edge is discarded.
- Grant latency: req sampled high at edge k in IDLE -> gnt high after edge k; first write at edge k+1; q and q_valid visible after edge k+1.
- Write latency: data present on the owner's wdata slice at edge e is on q after edge e; q_valid is high for exactly that following cycle.
- Handover: zero idle cycles between owners; new gnt appears the cycle after the previous owner's final write or drop.
- Maximum continuous writes per grant: MAX_BURST; with MAX_BURST=1 grants rotate every write.
- Simultaneous requests after reset: requester 0 wins (ptr=0).
- gnt is always one-hot or zero; owner and gnt change only on edges.

## Test plan
- Reset: drive junk on req/wdata, rst=1 for 2 edges -> gnt=0, busy=0, q=0x00, q_valid=0; release rst with req=0 -> outputs unchanged.
- Single requester: req=4'b0100, wdata slice 2 = 0xA5 -> gnt=4'b0100 after 1 edge, q=0xA5 with q_valid=1 after 2nd edge; req drops -> IDLE, gnt=0 next edge.
- Burst limit (MAX_BURST=4): req=4'b0011 held, slice0 = 0x10..0x13 per cycle -> exactly 4 writes from requester 0, then gnt=4'b0010 with no gap, requester 1 writes next.
- Fair rotation: req=4'b1111 held, slice i = 0x0i -> grant order 0,1,2,3,0, each holding 4 writes; q_valid high every cycle after first grant.
- Sole owner at limit: only req[3]=1 held -> after 4 writes gnt stays 4'b1000, burst restarts, q_valid continuous.
- Reset mid-burst: during requester 1's 2nd write assert rst -> after edge q=0x00, gnt=0, q_valid=0; after rst release with req=4'b0010, requester 1 re-granted with fresh burst of 4.
